// File: rtl/tcn_actmem_banked.sv
// Banked activation memory: one read and one write per cycle on distinct banks, plus a row-parallel clear sweep.
// Optional output register stage enabled by defining TCN_ACTMEM_OUTREG_EN (read latency 2 instead of 1).
module tcn_actmem_banked #(
    parameter int unsigned NUM_WORDS  = 64,
    parameter int unsigned DATA_WIDTH = 80,
    parameter int unsigned NUM_BANKS  = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clr_i,
    output logic                         busy_o,
    input  logic                         wr_req_i,
    input  logic [$clog2(NUM_WORDS)-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0]        wr_data_i,
    input  logic [DATA_WIDTH-1:0]        wr_be_i,
    output logic                         wr_gnt_o,
    input  logic                         rd_req_i,
    input  logic [$clog2(NUM_WORDS)-1:0] rd_addr_i,
    output logic                         rd_gnt_o,
    output logic                         rd_valid_o,
    output logic [DATA_WIDTH-1:0]        rd_data_o
);

    localparam int unsigned BW   = $clog2(NUM_BANKS);
    localparam int unsigned ROWS = NUM_WORDS / NUM_BANKS;
    localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_e;

    state_e                  state_q, state_d;
    logic [RW-1:0]           row_q, row_d;
    logic [DATA_WIDTH-1:0]   mem_q [NUM_BANKS][ROWS];

    logic [BW-1:0]           rd_bank_c, wr_bank_c;
    logic [RW-1:0]           rd_row_c, wr_row_c;
    logic                    conflict_c;
    logic [DATA_WIDTH-1:0]   rd_word_c;
    logic                    rd_valid_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;

    // Low address bits select the bank so consecutive words spread across banks.
    assign rd_bank_c = rd_addr_i[BW-1:0];
    assign wr_bank_c = wr_addr_i[BW-1:0];
    assign rd_row_c  = RW'(rd_addr_i >> BW);
    assign wr_row_c  = RW'(wr_addr_i >> BW);

    assign busy_o     = (state_q == ST_CLEAR);
    assign conflict_c = rd_req_i && (rd_bank_c == wr_bank_c);
    assign rd_gnt_o   = rd_req_i && !busy_o;
    assign wr_gnt_o   = wr_req_i && !busy_o && !conflict_c;
    assign rd_word_c  = mem_q[rd_bank_c][rd_row_c];

    // Clear-sweep state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    // Next-state logic: sweep every row once, then return to idle.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_i) begin
                    state_d = ST_CLEAR;
                    row_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (row_q == RW'(ROWS - 1)) begin
                    state_d = ST_IDLE;
                    row_d   = '0;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                row_d   = '0;
            end
        endcase
    end

    // Storage: reset and clear zero whole rows; writes merge under the bit enable.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                for (int r = 0; r < int'(ROWS); r++) begin
                    mem_q[b][r] <= '0;
                end
            end
        end else if (busy_o) begin
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                mem_q[b][row_q] <= '0;
            end
        end else if (wr_gnt_o) begin
            mem_q[wr_bank_c][wr_row_c] <= (mem_q[wr_bank_c][wr_row_c] & ~wr_be_i)
                                        | (wr_data_i & wr_be_i);
        end
    end

    // Read data register; data is forced to zero when no read completes.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_gnt_o;
            rd_data_q  <= rd_gnt_o ? rd_word_c : '0;
        end
    end

`ifdef TCN_ACTMEM_OUTREG_EN
    logic                  rd_valid_q2;
    logic [DATA_WIDTH-1:0] rd_data_q2;

    // Extra output stage for timing closure on the wide read mux.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_valid_q2 <= 1'b0;
            rd_data_q2  <= '0;
        end else begin
            rd_valid_q2 <= rd_valid_q;
            rd_data_q2  <= rd_data_q;
        end
    end

    assign rd_valid_o = rd_valid_q2;
    assign rd_data_o  = rd_data_q2;
`else
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
`endif

endmodule
